// File: rtl/vertex_screen_mapper.sv
// rtl/vertex_screen_mapper.sv - perspective divide and viewport mapping of one homogeneous vertex
// A single restoring divider is reused for x then y; results are clamped to the screen.
module vertex_screen_mapper #(
    parameter int M        = 11,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SCALE_W  = 9,
    parameter int PIX_W    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [M-1:0]     in_x,
    input  logic signed [M-1:0]     in_y,
    input  logic signed [M-1:0]     in_z,
    input  logic signed [M-1:0]     in_w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W-1:0]        out_sx,
    output logic [PIX_W-1:0]        out_sy,
    output logic signed [M-1:0]     out_z,
    output logic                    out_clipped,
    output logic                    out_offscreen
);
    localparam int NW = M + SCALE_W;
    localparam int SW = NW + 2;
    localparam int CW = $clog2(NW);

    localparam logic [NW-1:0]        HALF_W_N = NW'(SCREEN_W / 2);
    localparam logic [NW-1:0]        HALF_H_N = NW'(SCREEN_H / 2);
    localparam logic signed [SW-1:0] HALF_W_S = SW'(SCREEN_W / 2);
    localparam logic signed [SW-1:0] HALF_H_S = SW'(SCREEN_H / 2);
    localparam logic signed [SW-1:0] MAX_X_S  = SW'(SCREEN_W - 1);
    localparam logic signed [SW-1:0] MAX_Y_S  = SW'(SCREEN_H - 1);
    localparam logic [CW-1:0]        LAST     = CW'(NW - 1);

    typedef enum logic [2:0] {IDLE, DIV_X, DIV_Y, FINAL, OUT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NW-1:0]          num_q, num_d;
    logic [M-1:0]           rem_q, rem_d;
    logic [NW-1:0]          quot_q, quot_d;
    logic [NW-1:0]          qx_q, qx_d;
    logic [M-1:0]           ay_q, ay_d;
    logic [M-1:0]           w_q, w_d;
    logic                   negx_q, negx_d;
    logic                   negy_q, negy_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [PIX_W-1:0]       out_sx_q, out_sx_d;
    logic [PIX_W-1:0]       out_sy_q, out_sy_d;
    logic signed [M-1:0]    out_z_q, out_z_d;
    logic                   out_clipped_q, out_clipped_d;
    logic                   out_offscreen_q, out_offscreen_d;

    logic [M:0]             trial;
    logic [M-1:0]           sub;
    logic                   ge;
    logic [M-1:0]           rem_next;
    logic [NW-1:0]          q_next;
    logic [M-1:0]           ax;
    logic [M-1:0]           ay;
    logic                   w_nonpos;
    logic signed [SW-1:0]   qx_s;
    logic signed [SW-1:0]   qy_s;
    logic signed [SW-1:0]   sx_raw;
    logic signed [SW-1:0]   sy_raw;

    // Remainder stays below w, so trial < 2w fits M+1 bits and the low M bits of the difference are exact.
    assign trial    = {rem_q, num_q[NW-1]};
    assign ge       = trial >= {1'b0, w_q};
    assign sub      = trial[M-1:0] - w_q;
    assign rem_next = ge ? sub : trial[M-1:0];
    assign q_next   = {quot_q[NW-2:0], ge};

    // Magnitudes are unsigned M bits so that -2^(M-1) maps to 2^(M-1) without overflow.
    assign ax       = in_x[M-1] ? ({M{1'b0}} - in_x) : in_x;
    assign ay       = in_y[M-1] ? ({M{1'b0}} - in_y) : in_y;
    assign w_nonpos = in_w[M-1] || (in_w == '0);

    assign qx_s   = {2'b00, qx_q};
    assign qy_s   = {2'b00, quot_q};
    assign sx_raw = negx_q ? (HALF_W_S - qx_s) : (HALF_W_S + qx_s);
    assign sy_raw = negy_q ? (HALF_H_S + qy_s) : (HALF_H_S - qy_s);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        num_d           = num_q;
        rem_d           = rem_q;
        quot_d          = quot_q;
        qx_d            = qx_q;
        ay_d            = ay_q;
        w_d             = w_q;
        negx_d          = negx_q;
        negy_d          = negy_q;
        in_ready_d      = in_ready_q;
        out_valid_d     = out_valid_q;
        out_sx_d        = out_sx_q;
        out_sy_d        = out_sy_q;
        out_z_d         = out_z_q;
        out_clipped_d   = out_clipped_q;
        out_offscreen_d = out_offscreen_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    out_z_d    = in_z;
                    if (w_nonpos) begin
                        state_d         = OUT;
                        out_valid_d     = 1'b1;
                        out_clipped_d   = 1'b1;
                        out_sx_d        = '0;
                        out_sy_d        = '0;
                        out_offscreen_d = 1'b0;
                    end else begin
                        state_d = DIV_X;
                        cnt_d   = '0;
                        num_d   = NW'(ax) * HALF_W_N;
                        rem_d   = '0;
                        quot_d  = '0;
                        ay_d    = ay;
                        w_d     = in_w;
                        negx_d  = in_x[M-1];
                        negy_d  = in_y[M-1];
                    end
                end
            end

            DIV_X, DIV_Y: begin
                num_d  = {num_q[NW-2:0], 1'b0};
                rem_d  = rem_next;
                quot_d = q_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (state_q == DIV_X) begin
                        state_d = DIV_Y;
                        qx_d    = q_next;
                        num_d   = NW'(ay_q) * HALF_H_N;
                        rem_d   = '0;
                        quot_d  = '0;
                    end else begin
                        state_d = FINAL;
                    end
                end
            end

            FINAL: begin
                state_d         = OUT;
                out_valid_d     = 1'b1;
                out_clipped_d   = 1'b0;
                out_offscreen_d = 1'b0;
                if (sx_raw[SW-1]) begin
                    out_sx_d        = '0;
                    out_offscreen_d = 1'b1;
                end else if (sx_raw > MAX_X_S) begin
                    out_sx_d        = PIX_W'(SCREEN_W - 1);
                    out_offscreen_d = 1'b1;
                end else begin
                    out_sx_d = sx_raw[PIX_W-1:0];
                end
                if (sy_raw[SW-1]) begin
                    out_sy_d        = '0;
                    out_offscreen_d = 1'b1;
                end else if (sy_raw > MAX_Y_S) begin
                    out_sy_d        = PIX_W'(SCREEN_H - 1);
                    out_offscreen_d = 1'b1;
                end else begin
                    out_sy_d = sy_raw[PIX_W-1:0];
                end
            end

            OUT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            num_q           <= '0;
            rem_q           <= '0;
            quot_q          <= '0;
            qx_q            <= '0;
            ay_q            <= '0;
            w_q             <= '0;
            negx_q          <= 1'b0;
            negy_q          <= 1'b0;
            in_ready_q      <= 1'b1;
            out_valid_q     <= 1'b0;
            out_sx_q        <= '0;
            out_sy_q        <= '0;
            out_z_q         <= '0;
            out_clipped_q   <= 1'b0;
            out_offscreen_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            num_q           <= num_d;
            rem_q           <= rem_d;
            quot_q          <= quot_d;
            qx_q            <= qx_d;
            ay_q            <= ay_d;
            w_q             <= w_d;
            negx_q          <= negx_d;
            negy_q          <= negy_d;
            in_ready_q      <= in_ready_d;
            out_valid_q     <= out_valid_d;
            out_sx_q        <= out_sx_d;
            out_sy_q        <= out_sy_d;
            out_z_q         <= out_z_d;
            out_clipped_q   <= out_clipped_d;
            out_offscreen_q <= out_offscreen_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_sx        = out_sx_q;
    assign out_sy        = out_sy_q;
    assign out_z         = out_z_q;
    assign out_clipped   = out_clipped_q;
    assign out_offscreen = out_offscreen_q;

endmodule

// File: doc/vertex_screen_mapper.md
Name: vertex_screen_mapper

Overview:
- Downstream of the vertex transform stage.
- Consumes one transformed homogeneous vertex (x, y, z, w), each M-bit signed integer as produced by the transform stage after its >>>2N rescale.
- Performs the perspective divide and viewport mapping with a single shared sequential restoring divider.
- Emits screen-space pixel coordinates, with clip and off-screen flags, to the rasteriser over a valid/ready handshake.

Parameters:
- M, 11, width of each signed input component (matches transform stage output width).
- SCREEN_W, 640, screen width in pixels.
- SCREEN_H, 480, screen height in pixels.
- SCALE_W, 9, bits needed to hold SCREEN_W/2 and SCREEN_H/2; both must be < 2^SCALE_W.
- PIX_W, 10, output pixel coordinate width; SCREEN_W-1 and SCREEN_H-1 must fit unsigned.

Derived: NW = M + SCALE_W, the divider iteration count and numerator magnitude width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input vertex valid.
- in_ready  output  1  block can accept a vertex.
- in_x, in_y, in_z, in_w  input  M each, signed  homogeneous vertex components.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sx  output  PIX_W  screen x, clamped to [0, SCREEN_W-1].
- out_sy  output  PIX_W  screen y, clamped to [0, SCREEN_H-1], origin top-left.
- out_z  output  M, signed  in_z passed through unchanged.
- out_clipped  output  1  w <= 0; vertex behind the eye.
- out_offscreen  output  1  at least one unclamped coordinate fell outside the screen.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - All outputs become 0, except in_ready, which becomes 1 after the edge.
  - Any in-flight vertex is discarded; a reset mid-divide yields no output.
- States: IDLE, DIV_X, DIV_Y, FINAL, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, capture x, y, z, w.
  - If w <= 0: go directly to OUT with out_clipped=1, out_sx=out_sy=0, out_offscreen=0, out_z=z.
  - Otherwise go to DIV_X.
- DIV_X (exactly NW cycles):
  - Unsigned restoring divide of |x|*(SCREEN_W/2) by w, one quotient bit per cycle, MSB first.
  - Numerator magnitude is NW bits; the product is formed at capture or on DIV_X entry.
  - The signs of x and y are stored.
- DIV_Y (exactly NW cycles): same divider, numerator |y|*(SCREEN_H/2).
- FINAL (1 cycle):
  - Apply signs; quotients truncate toward zero.
  - sx_raw = SCREEN_W/2 + qx.
  - sy_raw = SCREEN_H/2 - qy (y axis flipped).
  - Both computed signed at NW+2 bits, with no overflow possible.
  - Clamp each to [0, dim-1].
  - out_offscreen=1 if either raw value is outside its range; raw value exactly equal to dim counts as offscreen.
- OUT:
  - out_valid=1; all outputs held stable until out_ready=1.
  - On the out_valid && out_ready edge, return to IDLE and drop out_valid.
  - Output data regs keep their value after the handshake; they are don't-care.
- in_ready is 1 only in IDLE; it is never asserted in the same cycle as out_valid.
- in_valid is ignored outside IDLE; the source must hold its data until the handshake.
- Latency:
  - The vertex is accepted at edge t0.
  - For w > 0, out_valid is first high after edge t0 + 2*NW + 2. With defaults, NW=20, so this is t0+42.
  - For w <= 0, out_valid is high after edge t0+1.
- Throughput: one vertex per 2*NW+3 cycles minimum with out_ready tied high.
- Divider is never invoked with w <= 0, so no divide-by-zero is possible.
- Most-negative inputs (x = -2^(M-1)) are legal; the magnitude fits NW bits.

Test Plan:
- Basic map: x=100, y=50, z=7, w=200 -> sx=480, sy=180, z=7, clipped=0, offscreen=0; out_valid after exactly 42 edges (defaults).
- Sign and truncation: x=-1, y=1, w=3 -> qx=-106, so sx=214; qy=80, so sy=160. Then x=1 -> sx=426.
- Clamp: x=300, y=-120, w=100 -> sx=639, sy=479, offscreen=1. Then x=100, w=100 -> sx=639 (raw 640), offscreen=1.
- Clip: w=0 and w=-5 with any x/y -> out_valid after 1 edge, clipped=1, sx=sy=0, z passed through.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout. Next vertex is accepted only after the handshake, and no vertex is lost or duplicated over a 50-vertex random stream checked against a reference model.
- Reset mid-operation: assert rst during DIV_Y -> next cycle out_valid=0, in_ready=1, all outputs 0. A new vertex then processes correctly with full latency.
